mini_rv_top: RTL and testbench
==============================

// Module: mini_rv_top
// PURPOSE
//   Top level of the mini RISC-V board design: a small single-cycle RV32E-subset core with 256-word IMEM.
//   It also contains a UART (8N1) program loader, LED and UART MMIO, a hex seven-segment debug display, a divided clock output and a 96-bit unlock key.
//   It is the FPGA top: board pins connect directly to it.
// PARAMETERS
//   CLK_HZ      100_000_000  system clock frequency
//   BAUD        115200       UART bit rate; bit period = CLK_HZ/BAUD cycles
//   IMEM_WORDS  256          instruction memory depth, 32-bit words
//   KEY_VALUE   96'h3cf3cf3cf3cf_30c30c_bae_3cf   unlock key
//   REFRESH_LOG2 16          seven-seg digit dwell = 2**REFRESH_LOG2 cycles
// PORTS
//   clk          in   1   system clock, rising edge
//   Rst          in   1   asynchronous, active-low reset
//   debug        in   1   1 = core frozen, display register selected by debug_input
//   debug_input  in   5   display select: 0-15 = x0-x15, 16-31 = PC
//   rx           in   1   UART receive, idle high
//   prog         in   1   1 = program-load mode
//   key          in   96  unlock key
//   tx           out  1   UART transmit, idle high
//   clk_out      out  1   clk / 2
//   sev_out      out  7   segments {g..a}, active-low
//   an           out  8   digit anodes, active-low, one-hot-low
//   led          out  16  LED register
// BEHAVIOUR
//   Reset (Rst=0, async):
//   - Cleared: PC=0, x1-x15=0, led=0, tx=1, clk_out=0, an=8'hFF, sev_out=7'h7F.
//   - UART RX/TX FSMs go IDLE; the load pointer clears; IMEM contents are kept.
//   Run condition: Rst=1, prog=0, debug=0, unlocked, TX not stalling.
//   - One instruction retires per cycle.
//   - Otherwise PC and registers hold.
//   Instructions:
//   - Supported: LUI, ADDI, ADD, SUB, AND, OR, XOR, SLT, BEQ, BNE, JAL, LW, SW.
//   - rd/rs fields use only bits [3:0]; x0 always reads 0.
//   - Any other encoding is a NOP (PC+4).
//   - Branch and JAL targets are PC+imm; JAL writes PC+4 to rd.
//   - PC wraps modulo IMEM_WORDS*4.
//   MMIO (the only data space):
//   - SW 0x8000_0000: led <= rs2[15:0].
//   - SW 0x8000_0004: send rs2[7:0] on UART. If TX is busy, the core stalls until TX is idle, then the store retires.
//   - LW 0x8000_0008: returns {23'b0, rx_valid, rx_byte}; the read clears rx_valid.
//   - Other addresses: SW is ignored, LW returns 0.
//   UART RX:
//   - Start bit is detected on a falling edge and validated at mid-bit; 8 data bits LSB first; stop bit must be 1 or the byte is dropped.
//   - A byte arriving while rx_valid=1 overwrites rx_byte.
//   UART TX: start bit, 8 data bits LSB first, stop bit; busy from load until the end of the stop bit.
//   prog=1:
//   - Core frozen, PC forced to 0.
//   - Received bytes assemble little-endian into words; each 4th byte writes IMEM[ptr] and then ptr++ (wraps).
//   - prog falling edge: ptr=0 and any partial word is discarded; execution starts from PC=0.
//   Display:
//   - The 32-bit value (debug=1: selected register/PC; debug=0: PC) is shown as 8 hex digits; an[0] is the LS nibble.
//   - The scan rotates every 2**REFRESH_LOG2 cycles.
//   clk_out toggles every clk rising edge.
// CONFIGURATION
//   RV_LOGIC_LOCK_EN defined:
//   - Unlocked only when key==KEY_VALUE, compared combinationally every cycle.
//   - Locked: core frozen, led forced to 0, every digit displays '-' (7'b0111111).
//   - UART loader still works while locked.
//   RV_LOGIC_LOCK_EN undefined: key is ignored and the block is always unlocked.
// TESTING
//   - Rst=0 for 10 ns, then release: tx=1, led=0, an=8'hFF during reset; PC=0 immediately after release.
//   - prog=1 and send bytes 93 00 50 00 (ADDI x1,x0,5), then prog=0, debug=1, debug_input=1: the display shows 00000005.
//   - Program: LUI x2,0x80000; ADDI x3,x0,0xA5; SW x3,0(x2) -> led=16'h00A5 within 3 cycles of the run starting.
//   - SW 0x41 to 0x8000_0004 -> tx shows frame 0,1,0,0,0,0,0,1,0,1 at BAUD; a back-to-back second SW stalls the PC until the first frame's stop bit ends.
//   - With RV_LOGIC_LOCK_EN and key=0: PC stays 0, led=0, all digits show '-'; setting key=KEY_VALUE resumes execution.
//   - clk_out: after reset it has half the clk frequency and 50% duty.

Source files
------------

// File: rtl/mini_rv_top.sv
// mini_rv_top: single-cycle RV32E-subset core with UART program loader, LED/UART MMIO, hex display and clk/2 output.
// Defining RV_LOGIC_LOCK_EN gates execution, LEDs and display on a 96-bit unlock key.
module mini_rv_top #(
    parameter int          CLK_HZ       = 100_000_000,
    parameter int          BAUD         = 115200,
    parameter int          IMEM_WORDS   = 256,
    parameter logic [95:0] KEY_VALUE    = 96'h3cf3cf3cf3cf_30c30c_bae_3cf,
    parameter int          REFRESH_LOG2 = 16
) (
    input  logic        clk,
    input  logic        Rst,
    input  logic        debug,
    input  logic [4:0]  debug_input,
    input  logic        rx,
    input  logic        prog,
    input  logic [95:0] key,
    output logic        tx,
    output logic        clk_out,
    output logic [6:0]  sev_out,
    output logic [7:0]  an,
    output logic [15:0] led
);
    localparam int AW = $clog2(IMEM_WORDS);
    localparam logic [15:0] BIT_M1 = 16'(CLK_HZ / BAUD - 1);
    localparam logic [15:0] HALF_M1 = 16'(CLK_HZ / BAUD / 2 - 1);
    localparam logic [31:0] PC_MASK = 32'(IMEM_WORDS * 4 - 1);
    localparam logic [6:0] HEX [16] = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h07,
                                        7'h7f, 7'h6f, 7'h77, 7'h7c, 7'h39, 7'h5e, 7'h79, 7'h71};

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;

    logic [31:0] imem_q [IMEM_WORDS];
    logic [31:0] rf_q [16], rf_d [16];
    logic [31:0] pc_q, pc_d, ld_word_q, ld_word_d;
    logic [15:0] led_q, led_d, rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [1:0] ld_cnt_q, ld_cnt_d;
    logic [7:0] rx_sh_q, rx_sh_d, rx_byte_q, rx_byte_d, an_q, an_d;
    logic [2:0] rx_bit_q, rx_bit_d, dig_q, dig_d;
    logic [9:0] tx_sh_q, tx_sh_d;
    logic [3:0] tx_bit_q, tx_bit_d;
    logic [6:0] sev_q, sev_d;
    logic [REFRESH_LOG2-1:0] ref_q, ref_d;
    rx_state_e rx_state_q, rx_state_d;
    logic rx_valid_q, rx_valid_d, tx_busy_q, tx_busy_d, clk_out_q, rx_s1_q, rx_s2_q, rx_p_q;
    logic rx_done, imem_we, unlocked;

    logic [31:0] instr, a, b, imm_i, imm_s, imm_b, imm_j, alu_r, ld_val, wdata, addr_ld, addr_st, disp_val;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [3:0] rd;
    logic is_lui, is_addi, is_r, is_br, is_jal, is_lw, is_sw, take, st_led, st_tx, ld_rx, stall, run, we;

`ifdef RV_LOGIC_LOCK_EN
    assign unlocked = key == KEY_VALUE;
`else
    logic unused_key;
    assign unused_key = ^key;
    assign unlocked = 1'b1;
`endif

    assign instr = imem_q[pc_q[AW+1:2]];
    assign opc = instr[6:0];
    assign f3 = instr[14:12];
    assign rd = instr[10:7];
    assign a = rf_q[instr[18:15]];
    assign b = rf_q[instr[23:20]];
    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign is_lui = opc == 7'b0110111;
    assign is_addi = opc == 7'b0010011 && f3 == 3'd0;
    assign is_r = opc == 7'b0110011 && ((instr[31:25] == 7'h00 && f3 inside {3'd0, 3'd2, 3'd4, 3'd6, 3'd7})
                                       || (instr[31:25] == 7'h20 && f3 == 3'd0));
    assign is_br = opc == 7'b1100011 && f3[2:1] == 2'b00;
    assign is_jal = opc == 7'b1101111;
    assign is_lw = opc == 7'b0000011 && f3 == 3'd2;
    assign is_sw = opc == 7'b0100011 && f3 == 3'd2;
    assign addr_ld = a + imm_i;
    assign addr_st = a + imm_s;
    assign st_led = is_sw && addr_st == 32'h8000_0000;
    assign st_tx = is_sw && addr_st == 32'h8000_0004;
    assign ld_rx = is_lw && addr_ld == 32'h8000_0008;
    assign stall = st_tx && tx_busy_q;
    assign run = !prog && !debug && unlocked && !stall;
    assign we = run && rd != 4'd0 && (is_lui || is_addi || is_r || is_jal || is_lw);
    assign take = is_br && ((a == b) != f3[0]);
    assign alu_r = f3 == 3'd0 ? (instr[30] ? a - b : a + b) : f3 == 3'd7 ? a & b : f3 == 3'd6 ? a | b :
                   f3 == 3'd4 ? a ^ b : {31'd0, $signed(a) < $signed(b)};
    assign ld_val = ld_rx ? {23'd0, rx_valid_q, rx_byte_q} : 32'd0;
    assign wdata = is_lui ? {instr[31:12], 12'd0} : is_addi ? addr_ld : is_jal ? pc_q + 32'd4 :
                   is_lw ? ld_val : alu_r;
    assign disp_val = debug ? (debug_input[4] ? pc_q : rf_q[debug_input[3:0]]) : pc_q;

    always_comb begin
        rf_d = rf_q;
        if (we) rf_d[rd] = wdata;
        pc_d = prog ? 32'd0 : run ? (pc_q + (is_jal ? imm_j : take ? imm_b : 32'd4)) & PC_MASK : pc_q;
        led_d = run && st_led ? b[15:0] : led_q;
        // Bytes received in program-load mode feed IMEM; otherwise they go to the MMIO receive register.
        rx_byte_d = rx_done && !prog ? rx_sh_q : rx_byte_q;
        rx_valid_d = (rx_done && !prog) || (rx_valid_q && !(run && ld_rx));
        ld_word_d = rx_done && prog ? {rx_sh_q, ld_word_q[31:8]} : ld_word_q;
        ld_cnt_d = !prog ? 2'd0 : rx_done ? ld_cnt_q + 2'd1 : ld_cnt_q;
        imem_we = prog && rx_done && ld_cnt_q == 2'd3;
        ptr_d = !prog ? '0 : imem_we ? ptr_q + 1'b1 : ptr_q;
        ref_d = ref_q + 1'b1;
        dig_d = &ref_q ? dig_q + 3'd1 : dig_q;
        an_d = ~(8'd1 << dig_q);
        sev_d = unlocked ? ~HEX[disp_val[{dig_q, 2'b00} +: 4]] : 7'b0111111;
    end

    always_comb begin
        tx_sh_d = tx_sh_q;
        tx_cnt_d = tx_cnt_q;
        tx_bit_d = tx_bit_q;
        tx_busy_d = tx_busy_q;
        if (run && st_tx) begin
            tx_sh_d = {1'b1, b[7:0], 1'b0};
            tx_cnt_d = '0;
            tx_bit_d = '0;
            tx_busy_d = 1'b1;
        end else if (tx_busy_q) begin
            tx_cnt_d = tx_cnt_q + 16'd1;
            if (tx_cnt_q == BIT_M1) begin
                tx_cnt_d = '0;
                tx_sh_d = {1'b1, tx_sh_q[9:1]};
                tx_bit_d = tx_bit_q + 4'd1;
                tx_busy_d = tx_bit_q != 4'd9;
            end
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d = rx_cnt_q + 16'd1;
        rx_bit_d = rx_bit_q;
        rx_sh_d = rx_sh_q;
        rx_done = 1'b0;
        case (rx_state_q)
            R_IDLE: begin
                rx_cnt_d = '0;
                if (!rx_s2_q && rx_p_q) rx_state_d = R_START;
            end
            R_START: if (rx_cnt_q == HALF_M1) begin
                rx_cnt_d = '0;
                rx_bit_d = '0;
                rx_state_d = rx_s2_q ? R_IDLE : R_DATA;
            end
            R_DATA: if (rx_cnt_q == BIT_M1) begin
                rx_cnt_d = '0;
                rx_sh_d = {rx_s2_q, rx_sh_q[7:1]};
                rx_bit_d = rx_bit_q + 3'd1;
                if (rx_bit_q == 3'd7) rx_state_d = R_STOP;
            end
            R_STOP: if (rx_cnt_q == BIT_M1) begin
                rx_state_d = R_IDLE;
                rx_done = rx_s2_q;
            end
            default: rx_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) if (imem_we) imem_q[ptr_q] <= ld_word_d;

    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            rf_q <= '{default: '0};
            pc_q <= '0;
            led_q <= '0;
            ld_word_q <= '0;
            ld_cnt_q <= '0;
            ptr_q <= '0;
            rx_byte_q <= '0;
            rx_valid_q <= 1'b0;
            rx_state_q <= R_IDLE;
            rx_cnt_q <= '0;
            rx_bit_q <= '0;
            rx_sh_q <= '0;
            {rx_s1_q, rx_s2_q, rx_p_q} <= 3'b111;
            tx_sh_q <= '1;
            tx_cnt_q <= '0;
            tx_bit_q <= '0;
            tx_busy_q <= 1'b0;
            ref_q <= '0;
            dig_q <= '0;
            an_q <= 8'hff;
            sev_q <= 7'h7f;
            clk_out_q <= 1'b0;
        end else begin
            rf_q <= rf_d;
            pc_q <= pc_d;
            led_q <= led_d;
            ld_word_q <= ld_word_d;
            ld_cnt_q <= ld_cnt_d;
            ptr_q <= ptr_d;
            rx_byte_q <= rx_byte_d;
            rx_valid_q <= rx_valid_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q <= rx_cnt_d;
            rx_bit_q <= rx_bit_d;
            rx_sh_q <= rx_sh_d;
            {rx_s1_q, rx_s2_q, rx_p_q} <= {rx, rx_s1_q, rx_s2_q};
            tx_sh_q <= tx_sh_d;
            tx_cnt_q <= tx_cnt_d;
            tx_bit_q <= tx_bit_d;
            tx_busy_q <= tx_busy_d;
            ref_q <= ref_d;
            dig_q <= dig_d;
            an_q <= an_d;
            sev_q <= sev_d;
            clk_out_q <= ~clk_out_q;
        end
    end

    assign tx = tx_sh_q[0];
    assign clk_out = clk_out_q;
    assign sev_out = sev_q;
    assign an = an_q;
    assign led = unlocked ? led_q : 16'd0;
endmodule

// File: tb/tb_mini_rv_top.sv
// tb_mini_rv_top: directed program loads over UART, then register/PC readback through the seven-segment scan.
module tb_mini_rv_top;
    localparam logic [95:0] KEY = 96'h3cf3cf3cf3cf_30c30c_bae_3cf;
    localparam logic [6:0] SEGL [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                         7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0e};
    localparam logic [31:0] PA [2] = '{32'h00500093, 32'h0000006f};
    localparam logic [31:0] PB [8] = '{32'h80000137, 32'h0a500193, 32'h00312023, 32'h04100213,
                                       32'h00412223, 32'h00412223, 32'h00100293, 32'h0000006f};
    localparam logic [31:0] PC [18] = '{32'h00700093, 32'h00300113, 32'h402081b3, 32'h0020f233,
                                        32'h0020e2b3, 32'h0020c333, 32'h001123b3, 32'h00618463,
                                        32'h00100413, 32'h002084b3, 32'h00109463, 32'h0080056f,
                                        32'h00100593, 32'h800006b7, 32'h0086a603, 32'hfe060ee3,
                                        32'h0086a703, 32'h0000006f};
    localparam logic [4:0] CI [13] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12,
                                       5'd13, 5'd14, 5'd16};
    localparam logic [31:0] CE [13] = '{32'd4, 32'd3, 32'd7, 32'd4, 32'd1, 32'd0, 32'd10, 32'd48, 32'd0,
                                        32'h15a, 32'h8000_0000, 32'h5a, 32'h44};

    logic clk = 1'b0, Rst, debug, rx, prog, tx, clk_out;
    logic [4:0] debug_input;
    logic [95:0] key;
    logic [6:0] sev_out;
    logic [7:0] an;
    logic [15:0] led;
    int vecs = 0, errs = 0;

    always #5 clk = ~clk;

    mini_rv_top #(.CLK_HZ(16_000_000), .BAUD(1_000_000), .IMEM_WORDS(256), .KEY_VALUE(KEY), .REFRESH_LOG2(2)) dut (
        .clk(clk), .Rst(Rst), .debug(debug), .debug_input(debug_input), .rx(rx), .prog(prog), .key(key),
        .tx(tx), .clk_out(clk_out), .sev_out(sev_out), .an(an), .led(led)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d);
        logic [9:0] f;
        f = {1'b1, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            repeat (16) @(negedge clk);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[i*8 +: 8]);
    endtask

    task automatic read_disp(output logic [31:0] v);
        logic [3:0] nib;
        logic [7:0] want;
        int t;
        v = 'x;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            want = ~(8'd1 << i);
            t = 0;
            while (an !== want && t < 64) begin
                @(negedge clk);
                t++;
            end
            nib = 'x;
            for (int j = 0; j < 16; j++) if (sev_out === SEGL[j]) nib = 4'(j);
            if (an === want) v[i*4 +: 4] = nib;
        end
    endtask

    task automatic wait_tx_low();
        int t;
        t = 0;
        while (tx !== 1'b0 && t < 400) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic start_run();
        @(negedge clk);
        prog = 1'b0;
        debug = 1'b0;
    endtask

    initial begin
        logic [31:0] v;
        logic [9:0] fr;
        longint t1;
        int gap;
        logic all_dash;
        Rst = 1'b0;
        prog = 1'b0;
        debug = 1'b1;
        debug_input = 5'd16;
        rx = 1'b1;
        key = KEY;
        #8;
        check("rst_tx", tx, 1);
        check("rst_led", led, 0);
        check("rst_an", an, 8'hff);
        check("rst_sev", sev_out, 7'h7f);
        check("rst_clk_out", clk_out, 0);
        @(negedge clk);
        Rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("clk_out", clk_out, (k % 2 == 0) ? 32'd1 : 32'd0);
        end
        read_disp(v);
        check("pc_after_reset", v, 0);
        debug_input = 5'd1;
        read_disp(v);
        check("x1_after_reset", v, 0);

        prog = 1'b1;
        for (int i = 0; i < 2; i++) send_word(PA[i]);
        start_run();
        repeat (12) @(negedge clk);
        debug = 1'b1;
        debug_input = 5'd1;
        read_disp(v);
        check("progA_x1", v, 32'h5);
        debug_input = 5'd16;
        read_disp(v);
        check("progA_pc", v, 32'h4);

        prog = 1'b1;
        for (int i = 0; i < 8; i++) send_word(PB[i]);
        start_run();
        repeat (2) @(negedge clk);
        check("led_before_sw", led, 0);
        @(negedge clk);
        check("led_after_sw", led, 16'h00a5);
        wait_tx_low();
        t1 = $time;
        check("tx_start", tx, 0);
        fr = {1'b1, 8'h41, 1'b0};
        repeat (8) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            if (k > 0) repeat (16) @(negedge clk);
            check("tx_frame_bit", tx, fr[k]);
        end
        wait_tx_low();
        gap = int'(($time - t1) / 10);
        check("tx_second_frame_after_stop", (gap >= 160 && gap <= 162), 1);
        repeat (200) @(negedge clk);
        debug = 1'b1;
        debug_input = 5'd5;
        read_disp(v);
        check("progB_x5", v, 32'h1);
        debug_input = 5'd16;
        read_disp(v);
        check("progB_pc", v, 32'h1c);
        check("progB_led", led, 16'h00a5);

        prog = 1'b1;
        for (int i = 0; i < 18; i++) send_word(PC[i]);
        start_run();
        repeat (40) @(negedge clk);
        send_byte(8'h5a);
        repeat (20) @(negedge clk);
        debug = 1'b1;
        for (int i = 0; i < 13; i++) begin
            debug_input = CI[i];
            read_disp(v);
            check("progC_reg", v, CE[i]);
        end

`ifdef RV_LOGIC_LOCK_EN
        key = '0;
        prog = 1'b1;
        for (int i = 0; i < 8; i++) send_word(PB[i]);
        start_run();
        repeat (10) @(negedge clk);
        check("locked_led", led, 0);
        all_dash = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (sev_out !== 7'b0111111) all_dash = 1'b0;
        end
        check("locked_dash", all_dash, 1);
        key = KEY;
        repeat (400) @(negedge clk);
        debug = 1'b1;
        debug_input = 5'd16;
        read_disp(v);
        check("unlocked_pc", v, 32'h1c);
        check("unlocked_led", led, 16'h00a5);
`else
        all_dash = 1'b0;
        key = '0;
        repeat (4) @(negedge clk);
        check("nolock_led_ignores_key", led, 16'h00a5);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
